// File: rtl/rx_sync_framer.sv
// rtl/rx_sync_framer.sv - serial sync-word hunter and payload deframer with valid/ready output
//
// Hunts a serial bit stream for SYNC_WORD, then assembles FRAME_LEN payload words of
// DATA_W bits each and hands them out through a one-entry output register.
//
// Ports:
//   clk_i          clock, all state on the rising edge
//   rst_i          asynchronous active-high reset
//   enable_i       0 = idle: FSM back to HUNT, counters and shift registers cleared
//   bit_valid_i    qualifies din_i, one serial bit per cycle when high
//   din_i          serial data bit
//   data_out_o     assembled payload word (output register)
//   data_valid_o   data_out_o holds an unread word
//   data_ready_i   consumer accepts the word when data_valid_o & data_ready_i
//   frame_start_o  qualified by data_valid_o: word is the first of its frame
//   frame_end_o    qualified by data_valid_o: word is the last of its frame
//   sync_locked_o  high while the FSM is in PAYLOAD
//   overrun_o      one-cycle pulse: a completed word was dropped, output register full

module rx_sync_framer #(
    parameter int                DATA_W    = 8,
    parameter int                SYNC_W    = 8,
    parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(8'hCD),
    parameter int                FRAME_LEN = 4,
    parameter bit                LSB_FIRST = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              bit_valid_i,
    input  logic              din_i,
    output logic [DATA_W-1:0] data_out_o,
    output logic              data_valid_o,
    input  logic              data_ready_i,
    output logic              frame_start_o,
    output logic              frame_end_o,
    output logic              sync_locked_o,
    output logic              overrun_o
);

    localparam int BC_W = $clog2(DATA_W + 1);
    localparam int WC_W = $clog2(FRAME_LEN + 1);
    localparam int HC_W = $clog2(SYNC_W + 1);

    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(DATA_W - 1);
    localparam logic [WC_W-1:0] WORD_LAST = WC_W'(FRAME_LEN - 1);
    localparam logic [HC_W-1:0] HUNT_LAST = HC_W'(SYNC_W - 1);
    localparam logic [HC_W-1:0] HUNT_SAT  = HC_W'(SYNC_W);

    typedef enum logic {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    state_t            state_q;
    logic [SYNC_W-1:0] sync_sr_q;
    logic [SYNC_W-1:0] sync_sr_d;
    logic [DATA_W-1:0] data_sr_q;
    logic [DATA_W-1:0] data_sr_d;
    logic [BC_W-1:0]   bit_cnt_q;
    logic [WC_W-1:0]   word_cnt_q;
    logic [HC_W-1:0]   hunt_cnt_q;

    logic [DATA_W-1:0] data_out_q;
    logic              data_valid_q;
    logic              frame_start_q;
    logic              frame_end_q;
    logic              overrun_q;

    logic shift_en;
    logic hunt_match;
    logic word_done;
    logic last_word;
    logic accept;
    logic load;

    // Next values of both shift registers; the register itself only takes them on a
    // qualified bit in the matching FSM state.
    always_comb begin
        sync_sr_d = sync_sr_q;
        data_sr_d = data_sr_q;
        if (LSB_FIRST) begin
            sync_sr_d = {din_i, sync_sr_q[SYNC_W-1:1]};
            data_sr_d = {din_i, data_sr_q[DATA_W-1:1]};
        end else begin
            sync_sr_d = {sync_sr_q[SYNC_W-2:0], din_i};
            data_sr_d = {data_sr_q[DATA_W-2:0], din_i};
        end
    end

    assign shift_en = enable_i & bit_valid_i;

    // A match needs a full SYNC_W bits seen since the hunt restarted, so stale zeros in
    // the cleared shift register can never form part of the sync word.
    assign hunt_match = (state_q == HUNT) && shift_en &&
                        (sync_sr_d == SYNC_WORD) && (hunt_cnt_q >= HUNT_LAST);

    assign word_done = (state_q == PAYLOAD) && shift_en && (bit_cnt_q == BIT_LAST);
    assign last_word = (word_cnt_q == WORD_LAST);

    // The output register can take a new word when empty or when its current word
    // leaves in this same cycle.
    assign accept = data_valid_q & data_ready_i;
    assign load   = word_done & (~data_valid_q | accept);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= HUNT;
            sync_sr_q     <= '0;
            data_sr_q     <= '0;
            bit_cnt_q     <= '0;
            word_cnt_q    <= '0;
            hunt_cnt_q    <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            // Output register: runs regardless of enable so a pending word still drains.
            overrun_q <= 1'b0;
            if (load) begin
                data_out_q    <= data_sr_d;
                data_valid_q  <= 1'b1;
                frame_start_q <= (word_cnt_q == '0);
                frame_end_q   <= last_word;
            end else begin
                if (accept) begin
                    data_valid_q <= 1'b0;
                end
                // A completed word that could not be loaded is dropped.
                if (word_done) begin
                    overrun_q <= 1'b1;
                end
            end

            // Framer FSM
            if (!enable_i) begin
                state_q    <= HUNT;
                sync_sr_q  <= '0;
                data_sr_q  <= '0;
                bit_cnt_q  <= '0;
                word_cnt_q <= '0;
                hunt_cnt_q <= '0;
            end else if (bit_valid_i) begin
                case (state_q)
                    HUNT: begin
                        sync_sr_q <= sync_sr_d;
                        if (hunt_cnt_q != HUNT_SAT) begin
                            hunt_cnt_q <= hunt_cnt_q + 1'b1;
                        end
                        if (hunt_match) begin
                            state_q    <= PAYLOAD;
                            bit_cnt_q  <= '0;
                            word_cnt_q <= '0;
                        end
                    end
                    PAYLOAD: begin
                        data_sr_q <= data_sr_d;
                        if (word_done) begin
                            bit_cnt_q  <= '0;
                            word_cnt_q <= word_cnt_q + 1'b1;
                            // Payload bits never feed the sync hunter: it restarts empty.
                            if (last_word) begin
                                state_q    <= HUNT;
                                sync_sr_q  <= '0;
                                hunt_cnt_q <= '0;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= HUNT;
                    end
                endcase
            end
        end
    end

    assign data_out_o    = data_out_q;
    assign data_valid_o  = data_valid_q;
    assign frame_start_o = frame_start_q;
    assign frame_end_o   = frame_end_q;
    assign overrun_o     = overrun_q;
    assign sync_locked_o = (state_q == PAYLOAD);

endmodule

// File: tb/tb_rx_sync_framer.sv
// tb/tb_rx_sync_framer.sv - self-checking bench for rx_sync_framer

`timescale 1ns/1ps

module tb_rx_sync_framer;

    typedef struct {
        int          u;
        logic [15:0] w;
        bit          s;
        bit          e;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        en0 = 1'b1, bv0 = 1'b0, din0 = 1'b0, rdy0 = 1'b0;
    logic [7:0]  dout0;
    logic        dv0, fs0, fe0, lk0, ov0;

    logic        en1 = 1'b1, bv1 = 1'b0, din1 = 1'b0, rdy1 = 1'b0;
    logic [15:0] dout1;
    logic        dv1, fs1, fe1, lk1, ov1;

    int checks = 0;
    int errors = 0;

    bit    seg_q[$];
    word_t exp_q[$];
    word_t got_q[$];
    int    gidx = 0;
    int    ovc0 = 0;
    int    ovc1 = 0;
    int    gap0 = 0;

    always #5 clk = ~clk;

    rx_sync_framer dut0 (
        .clk_i(clk), .rst_i(rst), .enable_i(en0), .bit_valid_i(bv0), .din_i(din0),
        .data_out_o(dout0), .data_valid_o(dv0), .data_ready_i(rdy0),
        .frame_start_o(fs0), .frame_end_o(fe0), .sync_locked_o(lk0), .overrun_o(ov0)
    );

    rx_sync_framer #(
        .DATA_W(16), .SYNC_W(8), .SYNC_WORD(8'hCD), .FRAME_LEN(2), .LSB_FIRST(1'b0)
    ) dut1 (
        .clk_i(clk), .rst_i(rst), .enable_i(en1), .bit_valid_i(bv1), .din_i(din1),
        .data_out_o(dout1), .data_valid_o(dv1), .data_ready_i(rdy1),
        .frame_start_o(fs1), .frame_end_o(fe1), .sync_locked_o(lk1), .overrun_o(ov1)
    );

    // Record every handshake that the next rising edge will complete.
    always @(negedge clk) begin
        if (!rst) begin
            if (dv0 && rdy0) got_q.push_back('{u: 0, w: {8'h00, dout0}, s: fs0, e: fe0});
            if (dv1 && rdy1) got_q.push_back('{u: 1, w: dout1, s: fs1, e: fe1});
            if (ov0) ovc0++;
            if (ov1) ovc1++;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference decoder over the recorded bit stream of one segment: sliding sync search,
    // then FRAME_LEN words cut straight out of the bit list; an unfinished frame yields
    // only its complete words.
    function automatic void model(input int u);
        int          dw, fl, n, i, hs, f;
        bit          lsb, ok;
        logic [15:0] w;
        logic [7:0]  sw;
        sw  = 8'hCD;
        dw  = (u == 0) ? 8 : 16;
        fl  = (u == 0) ? 4 : 2;
        lsb = (u == 0);
        n   = seg_q.size();
        i   = 0;
        hs  = 0;
        while (i < n) begin
            ok = (i - hs + 1 >= 8);
            if (ok) begin
                for (int k = 0; k < 8; k++) begin
                    if (seg_q[i-7+k] != (lsb ? sw[k] : sw[7-k])) ok = 1'b0;
                end
            end
            i++;
            if (ok) begin
                for (f = 0; f < fl && i + dw <= n; f++) begin
                    w = '0;
                    for (int k = 0; k < dw; k++) begin
                        if (lsb) w[k] = seg_q[i+k];
                        else     w[dw-1-k] = seg_q[i+k];
                    end
                    exp_q.push_back('{u: u, w: w, s: (f == 0), e: (f == fl - 1)});
                    i += dw;
                end
                if (f < fl) i = n;
                hs = i;
            end
        end
        seg_q.delete();
    endfunction

    task automatic sb0(input logic b);
        int g;
        g = (gap0 > 0) ? int'($urandom_range(gap0, 0)) : 0;
        repeat (g) begin @(posedge clk); #1; end
        din0 = b;
        bv0  = 1'b1;
        if (en0) seg_q.push_back(b);
        @(posedge clk); #1;
        bv0 = 1'b0;
    endtask

    task automatic sbyte0(input logic [7:0] v);
        for (int k = 0; k < 8; k++) sb0(v[k]);
    endtask

    // Unit 1 sees one qualified bit every third cycle.
    task automatic sb1(input logic b);
        repeat (2) begin @(posedge clk); #1; end
        din1 = b;
        bv1  = 1'b1;
        if (en1) seg_q.push_back(b);
        @(posedge clk); #1;
        bv1 = 1'b0;
    endtask

    task automatic new_seg0();
        en0 = 1'b0;
        @(posedge clk); #1;
        en0 = 1'b1;
        seg_q.delete();
    endtask

    task automatic check_frames(input string tag);
        int ng;
        repeat (12) begin @(posedge clk); #1; end
        ng = got_q.size() - gidx;
        chk(32'(ng), 32'(exp_q.size()), {tag, " word count"});
        for (int k = 0; k < exp_q.size() && k < ng; k++) begin
            chk(32'(got_q[gidx+k].w), 32'(exp_q[k].w), {tag, " word"});
            chk({30'd0, got_q[gidx+k].s, got_q[gidx+k].e},
                {30'd0, exp_q[k].s, exp_q[k].e}, {tag, " start/end"});
        end
        gidx = got_q.size();
        exp_q.delete();
    endtask

    initial begin
        int          ov_snap;
        logic [7:0]  rb;
        logic [15:0] w16;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk(32'(dout0), 0, "rst data_out");
        chk(32'(dv0), 0, "rst data_valid");
        chk(32'(fs0), 0, "rst frame_start");
        chk(32'(fe0), 0, "rst frame_end");
        chk(32'(lk0), 0, "rst sync_locked");
        chk(32'(ov0), 0, "rst overrun");
        chk(32'(dv1), 0, "rst data_valid u1");
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic frame, LSB first
        rdy0 = 1'b1;
        new_seg0();
        ov_snap = ovc0;
        sbyte0(8'hCD);
        chk(32'(lk0), 1, "t1 locked after sync");
        sbyte0(8'h11); sbyte0(8'h22); sbyte0(8'h33); sbyte0(8'h44);
        chk(32'(lk0), 0, "t1 unlocked after frame");
        model(0);
        check_frames("t1");
        chk(32'(ovc0 - ov_snap), 0, "t1 overrun count");

        // Sync inside noise; lock one cycle after the 16th bit; 0xCD in payload ignored
        new_seg0();
        sbyte0(8'hFF);
        for (int k = 0; k < 7; k++) sb0(1'((8'hCD >> k) & 8'h01));
        chk(32'(lk0), 0, "t2 not locked before 16th bit");
        sb0(1'b1);
        chk(32'(lk0), 1, "t2 locked after 16th bit");
        sbyte0(8'hCD); sbyte0(8'h12); sbyte0(8'hCD); sbyte0(8'h34);
        chk(32'(lk0), 0, "t2 no resync in payload");
        model(0);
        check_frames("t2");

        // Backpressure: word0 held, word1 dropped with one overrun pulse
        new_seg0();
        rdy0 = 1'b0;
        ov_snap = ovc0;
        sbyte0(8'hCD);
        sbyte0(8'hA1);
        chk(32'(dv0), 1, "t3 word0 valid");
        chk(32'(dout0), 32'hA1, "t3 word0 data");
        chk(32'(fs0), 1, "t3 word0 frame_start");
        sbyte0(8'hB2);
        chk(32'(ov0), 1, "t3 overrun pulse");
        chk(32'(dout0), 32'hA1, "t3 word0 held");
        @(posedge clk); #1;
        chk(32'(ov0), 0, "t3 overrun one cycle");
        rdy0 = 1'b1;
        sbyte0(8'hC3); sbyte0(8'hD4);
        model(0);
        exp_q.delete(1);
        check_frames("t3");
        chk(32'(ovc0 - ov_snap), 1, "t3 overrun count");

        // Accept and complete in the same cycle
        new_seg0();
        rdy0 = 1'b0;
        ov_snap = ovc0;
        sbyte0(8'hCD);
        sbyte0(8'h5A);
        for (int k = 0; k < 7; k++) sb0(1'((8'hA5 >> k) & 8'h01));
        rdy0 = 1'b1;
        sb0(1'b1);
        chk(32'(dv0), 1, "t4 valid stays high");
        chk(32'(dout0), 32'hA5, "t4 new data");
        chk(32'(ov0), 0, "t4 no overrun");
        sbyte0(8'h0F); sbyte0(8'hF0);
        model(0);
        check_frames("t4");
        chk(32'(ovc0 - ov_snap), 0, "t4 overrun count");

        // enable dropped mid-word
        new_seg0();
        sbyte0(8'hCD);
        sbyte0(8'h3C);
        sb0(1'b1); sb0(1'b0); sb0(1'b1);
        model(0);
        en0 = 1'b0;
        sb0(1'b1);
        chk(32'(lk0), 0, "t5 enable drop unlocks");
        for (int k = 0; k < 4; k++) sb0(1'($urandom));
        en0 = 1'b1;
        sbyte0(8'hCD);
        for (int k = 0; k < 4; k++) begin rb = 8'($urandom); sbyte0(rb); end
        model(0);
        check_frames("t5 enable");

        // rst mid-frame
        new_seg0();
        sbyte0(8'hCD);
        sbyte0(8'h77);
        for (int k = 0; k < 5; k++) sb0(1'($urandom));
        model(0);
        #3 rst = 1'b1;
        #1;
        chk(32'(lk0), 0, "t5 rst unlocks");
        chk(32'(dv0), 0, "t5 rst clears valid");
        @(posedge clk); #1;
        rst = 1'b0;
        seg_q.delete();
        sbyte0(8'hCD);
        for (int k = 0; k < 4; k++) begin rb = 8'($urandom); sbyte0(rb); end
        model(0);
        check_frames("t5 rst");

        // Randomised noise, payload and bit gaps
        gap0 = 2;
        for (int r = 0; r < 6; r++) begin
            new_seg0();
            repeat ($urandom_range(20, 0)) sb0(1'($urandom));
            sbyte0(8'hCD);
            for (int k = 0; k < 4; k++) begin rb = 8'($urandom); sbyte0(rb); end
            model(0);
            check_frames("rand");
        end
        gap0 = 0;

        // MSB first, 16-bit words, two words per frame, bit every third cycle
        rdy1 = 1'b1;
        en1 = 1'b0;
        @(posedge clk); #1;
        en1 = 1'b1;
        seg_q.delete();
        for (int k = 7; k >= 0; k--) sb1(1'((8'hCD >> k) & 8'h01));
        w16 = 16'hBEEF;
        for (int k = 15; k >= 1; k--) sb1(w16[k]);
        chk(32'(dv1), 0, "t6 not valid before 16th bit");
        sb1(w16[0]);
        chk(32'(dv1), 1, "t6 valid after 16th bit");
        chk(32'(dout1), 32'hBEEF, "t6 word0 data");
        chk(32'(fs1), 1, "t6 word0 frame_start");
        w16 = 16'h1234;
        for (int k = 15; k >= 0; k--) sb1(w16[k]);
        for (int k = 7; k >= 0; k--) sb1(1'((8'hCD >> k) & 8'h01));
        for (int j = 0; j < 2; j++) begin
            w16 = 16'($urandom);
            for (int k = 15; k >= 0; k--) sb1(w16[k]);
        end
        model(1);
        check_frames("t6");
        chk(32'(ovc1), 0, "t6 overrun count");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
